// File: rtl/framebuffer_dbuf.sv
// Two-bank frame store: scanout reads the front bank, the rasteriser and the
// clear engine write the back bank, and front/back swaps wait for vertical blank.
module framebuffer_dbuf #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int PIX_W  = 24,
    parameter int ADDR_W = 19
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [PIX_W-1:0]     rd_data,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [PIX_W-1:0]     wr_data,
    input  logic [PIX_W/8-1:0]   wr_be,
    input  logic                 clear_req,
    input  logic [PIX_W-1:0]     clear_color,
    input  logic                 swap_req,
    input  logic                 vblank,
    output logic                 front_sel,
    output logic                 swap_pending,
    output logic                 busy,
    output logic                 clear_done,
    output logic                 swap_done
);

    localparam int DEPTH = H_RES * V_RES;
    localparam int NBYTE = PIX_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_L  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W - 1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    logic [PIX_W-1:0]  mem [0:1][0:DEPTH-1];

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] cnt_r, cnt_s;
    logic [PIX_W-1:0]  color_r, color_s;
    logic              clr_bank_r, clr_bank_s;
    logic              front_sel_r;
    logic              swap_pending_r;
    logic              busy_r;
    logic              clear_done_r;
    logic              swap_done_r;
    logic [PIX_W-1:0]  rd_data_r;

    logic              take_swap_s;
    logic              last_s;
    logic              rd_in_range_s;
    logic              wr_in_range_s;
    logic              mem_we_s;
    logic              mem_bank_s;
    logic [IDX_W-1:0]  mem_idx_s;
    logic [PIX_W-1:0]  mem_data_s;
    logic [NBYTE-1:0]  mem_be_s;

    assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_L);
    assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_L);
    assign last_s        = ({1'b0, cnt_r} == LAST_L);

    // Clear FSM next state, swap decision and the single back-bank write port mux
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        color_s     = color_r;
        clr_bank_s  = clr_bank_r;
        take_swap_s = 1'b0;
        mem_we_s    = 1'b0;
        mem_bank_s  = ~front_sel_r;
        mem_idx_s   = wr_addr[IDX_W-1:0];
        mem_data_s  = wr_data;
        mem_be_s    = wr_be;
        case (state_r)
            ST_IDLE: begin
                take_swap_s = vblank & (swap_pending_r | swap_req);
                mem_we_s    = wr_en & wr_in_range_s;
                if (clear_req) begin
                    state_s    = ST_CLEAR;
                    cnt_s      = {ADDR_W{1'b0}};
                    color_s    = clear_color;
                    // a same-edge swap makes the current front the new back
                    clr_bank_s = take_swap_s ? front_sel_r : ~front_sel_r;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                mem_we_s   = 1'b1;
                mem_bank_s = clr_bank_r;
                mem_idx_s  = cnt_r[IDX_W-1:0];
                mem_data_s = color_r;
                mem_be_s   = {NBYTE{1'b1}};
                if (last_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = {ADDR_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + ONE_A;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            cnt_r          <= {ADDR_W{1'b0}};
            color_r        <= {PIX_W{1'b0}};
            clr_bank_r     <= 1'b0;
            front_sel_r    <= 1'b0;
            swap_pending_r <= 1'b0;
            busy_r         <= 1'b0;
            clear_done_r   <= 1'b0;
            swap_done_r    <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            color_r        <= color_s;
            clr_bank_r     <= clr_bank_s;
            front_sel_r    <= front_sel_r ^ take_swap_s;
            swap_pending_r <= take_swap_s ? 1'b0 : (swap_pending_r | swap_req);
            busy_r         <= (state_s == ST_CLEAR);
            clear_done_r   <= (state_r == ST_CLEAR) & last_s;
            swap_done_r    <= take_swap_s;
        end
    end

    // Registered scanout read from the current front bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {PIX_W{1'b0}};
        end else if (rd_in_range_s) begin
            rd_data_r <= mem[front_sel_r][rd_addr[IDX_W-1:0]];
        end else begin
            rd_data_r <= {PIX_W{1'b0}};
        end
    end

    // Byte-masked back-bank write; storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int k = 0; k < NBYTE; k++) begin
                if (mem_be_s[k]) begin
                    mem[mem_bank_s][mem_idx_s][8*k +: 8] <= mem_data_s[8*k +: 8];
                end
            end
        end
    end

    assign rd_data      = rd_data_r;
    assign front_sel    = front_sel_r;
    assign swap_pending = swap_pending_r;
    assign busy         = busy_r;
    assign clear_done   = clear_done_r;
    assign swap_done    = swap_done_r;

endmodule

// File: tb/tb_framebuffer_dbuf.sv
// Self-checking bench for framebuffer_dbuf on a reduced 16x8 frame: a bank/array
// model is compared every cycle, and directed literals pin the model.
module tb_framebuffer_dbuf;

    localparam int DEPTH = 128;
    localparam logic [8:0] DEP = 9'd128;

    logic        clk;
    logic        rst_n;
    logic [8:0]  rd_addr;
    logic [23:0] rd_data;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [23:0] wr_data;
    logic [2:0]  wr_be;
    logic        clear_req;
    logic [23:0] clear_color;
    logic        swap_req;
    logic        vblank;
    logic        front_sel;
    logic        swap_pending;
    logic        busy;
    logic        clear_done;
    logic        swap_done;

    framebuffer_dbuf #(
        .H_RES(16), .V_RES(8), .PIX_W(24), .ADDR_W(9)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .clear_req(clear_req), .clear_color(clear_color),
        .swap_req(swap_req), .vblank(vblank),
        .front_sel(front_sel), .swap_pending(swap_pending), .busy(busy),
        .clear_done(clear_done), .swap_done(swap_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit rd_on    = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: two banks as arrays, a clear as "cells remaining", swap as a flag.
    logic [23:0] m_mem [2][128];
    logic        m_front, m_pend, m_cbank;
    logic [23:0] m_ccol;
    int          m_left;
    logic [23:0] e_rd;
    logic        e_cdone, e_sdone;
    wire         m_idle = (m_left == 0);
    wire         m_sw   = vblank && (m_pend || swap_req) && m_idle;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_front <= 1'b0;
            m_pend  <= 1'b0;
            m_left  <= 0;
            e_rd    <= 24'h0;
            e_cdone <= 1'b0;
            e_sdone <= 1'b0;
        end else begin
            e_rd    <= (rd_addr < DEP) ? m_mem[m_front][rd_addr[6:0]] : 24'h0;
            e_sdone <= m_sw;
            e_cdone <= (m_left == 1);
            m_pend  <= m_sw ? 1'b0 : (m_pend || swap_req);
            if (m_sw) m_front <= !m_front;
            if (!m_idle) begin
                m_mem[m_cbank][7'(DEPTH - m_left)] <= m_ccol;
                m_left <= m_left - 1;
            end else begin
                if (wr_en && wr_addr < DEP) begin
                    for (int k = 0; k < 3; k++)
                        if (wr_be[k]) m_mem[!m_front][wr_addr[6:0]][8*k +: 8] <= wr_data[8*k +: 8];
                end
                if (clear_req) begin
                    m_left  <= DEPTH;
                    m_ccol  <= clear_color;
                    m_cbank <= m_sw ? m_front : !m_front;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        check("front_sel", {31'd0, front_sel}, {31'd0, m_front});
        check("swap_pending", {31'd0, swap_pending}, {31'd0, m_pend});
        check("busy", {31'd0, busy}, {31'd0, !m_idle});
        check("clear_done", {31'd0, clear_done}, {31'd0, e_cdone});
        check("swap_done", {31'd0, swap_done}, {31'd0, e_sdone});
        if (rd_on) check("rd_data", {8'd0, rd_data}, {8'd0, e_rd});
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_done(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < DEPTH + 8 && !seen; i++) begin
            step();
            seen = clear_done;
        end
        check(nm, {31'd0, seen}, 32'd1);
    endtask

    task automatic start_clear(input logic [23:0] col);
        clear_req = 1'b1; clear_color = col;
        step();
        clear_req = 1'b0;
    endtask

    task automatic do_swap();
        swap_req = 1'b1; vblank = 1'b1;
        step();
        swap_req = 1'b0; vblank = 1'b0;
    endtask

    task automatic write(input logic [8:0] a, input logic [23:0] d, input logic [2:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        step();
        wr_en = 1'b0;
    endtask

    task automatic read_chk(input string nm, input logic [8:0] a, input logic [23:0] exp);
        rd_addr = a;
        step();
        check(nm, {8'd0, rd_data}, {8'd0, exp});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbusy;
        rst_n = 1'b0; rd_addr = 9'd0; wr_en = 1'b0; wr_addr = 9'd0; wr_data = 24'd0;
        wr_be = 3'd0; clear_req = 1'b0; clear_color = 24'd0; swap_req = 1'b0; vblank = 1'b0;
        repeat (3) step();
        check("rst_rd_data", {8'd0, rd_data}, 32'd0);
        check("rst_front", {31'd0, front_sel}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pending", {31'd0, swap_pending}, 32'd0);
        rst_n = 1'b1;

        // Bring both banks to a known all-zero state
        start_clear(24'h0); wait_done("init_clear_a"); do_swap();
        start_clear(24'h0); wait_done("init_clear_b"); do_swap();
        rd_on = 1'b1;

        // Full-mask write, swap, read back
        write(9'd5, 24'hAABBCC, 3'b111);
        do_swap();
        check("t1_swap_done", {31'd0, swap_done}, 32'd1);
        check("t1_front", {31'd0, front_sel}, 32'd1);
        read_chk("t1_read5", 9'd5, 24'hAABBCC);

        // Partial byte enable keeps unselected bytes
        write(9'd7, 24'h112233, 3'b111);
        write(9'd7, 24'hFFFFFF, 3'b010);
        do_swap();
        read_chk("t2_read7", 9'd7, 24'h11FF33);
        check("t2_front", {31'd0, front_sel}, 32'd0);

        // Clear with busy length, dropped writes and a swap deferred past the clear
        start_clear(24'h00FF00);
        nbusy = 0;
        for (int i = 0; i < DEPTH + 8; i++) begin
            if (busy) nbusy++;
            if (i == 25) begin
                check("t3_front_hold", {31'd0, front_sel}, 32'd0);
                check("t3_pending", {31'd0, swap_pending}, 32'd1);
            end
            wr_en = (i == 50); wr_addr = 9'd10; wr_data = 24'h123456; wr_be = 3'b111;
            swap_req = (i == 10); vblank = (i == 20);
            step();
        end
        wr_en = 1'b0; swap_req = 1'b0; vblank = 1'b0;
        check("t3_busy_cycles", nbusy, DEPTH);
        check("t3_still_pending", {31'd0, swap_pending}, 32'd1);
        vblank = 1'b1; step(); vblank = 1'b0;
        check("t3_front_after", {31'd0, front_sel}, 32'd1);
        read_chk("t3_read0", 9'd0, 24'h00FF00);
        read_chk("t3_read64", 9'd64, 24'h00FF00);
        read_chk("t3_read127", 9'd127, 24'h00FF00);
        read_chk("t3_read10", 9'd10, 24'h00FF00);

        // Out-of-range read and write
        read_chk("t5_oob_read", 9'd128, 24'h0);
        write(9'd300, 24'hDEADBE, 3'b111);
        write(9'd128, 24'hDEADBE, 3'b111);
        do_swap();
        read_chk("t5_alias44", 9'd44, 24'h0);
        read_chk("t5_alias0", 9'd0, 24'h0);
        do_swap();

        // Reset in the middle of a clear leaves a partially cleared bank
        swap_req = 1'b1; step(); swap_req = 1'b0;
        check("t6_pending_set", {31'd0, swap_pending}, 32'd1);
        start_clear(24'h5A5A5A);
        repeat (50) step();
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy_rst", {31'd0, busy}, 32'd0);
        check("t6_front_rst", {31'd0, front_sel}, 32'd0);
        check("t6_pending_rst", {31'd0, swap_pending}, 32'd0);
        step();
        rst_n = 1'b1;
        read_chk("t6_read49", 9'd49, 24'h5A5A5A);
        read_chk("t6_read51", 9'd51, 24'h0);
        read_chk("t6_read50", 9'd50, 24'h0);
        read_chk("t6_read7", 9'd7, 24'h5A5A5A);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
